data_ram_ctrl: RTL and testbench

Responder end of the memory-stage load/store interface. It accepts one word-wide request at a time from the memory stage, inserts a configurable number of wait states, and performs a byte-lane-masked write or a full-word read on internal RAM. It returns a one-cycle acknowledge and raises a pipeline stall request while the access is outstanding. It sits beside the memory stage, outside the pipeline registers.

---
 rtl/data_ram_ctrl_pkg.sv | 30 +++
 rtl/data_ram_ctrl_array.sv | 37 +++
 rtl/data_ram_ctrl.sv | 122 ++++++++++++
 tb/tb_data_ram_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/data_ram_ctrl_pkg.sv
// Shared constants, bus types and FSM encoding for the data RAM controller.
// The optional DATA_RAM_ALIGN_CHECK_EN build option is handled in data_ram_ctrl.sv.
package data_ram_ctrl_pkg;

   localparam logic        RstEnable   = 1'b1;
   localparam logic [31:0] ZeroWord    = 32'h0000_0000;
   localparam logic        ChipEnable  = 1'b1;
   localparam logic        WriteEnable = 1'b1;

   typedef logic [31:0] data_addr_bus_t;
   typedef logic [31:0] data_bus_t;
   typedef logic [3:0]  byte_sel_bus_t;

   typedef enum logic [1:0] {
      DRamIdle = 2'd0,
      DRamBusy = 2'd1,
      DRamResp = 2'd2
   } dram_state_e;

   // Expand a byte-lane select into a 32-bit bit mask.
   function automatic data_bus_t lane_mask(input byte_sel_bus_t sel);
      data_bus_t m;
      m = ZeroWord;
      for (int i = 0; i < 4; i++) begin
         m[i*8 +: 8] = {8{sel[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/data_ram_ctrl_array.sv
// Four byte-wide lane memories with per-lane synchronous write and a
// registered, enable-gated read port sharing one word index.
module data_ram_array
   import data_ram_ctrl_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  byte_sel_bus_t         we,
   input  logic                  re,
   input  data_bus_t             wdata,
   output data_bus_t             rdata
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [0:DEPTH-1];
         logic [7:0] rd_reg;

         always_ff @(posedge clk) begin
            if (we[gi]) begin
               lane_mem[addr] <= wdata[gi*8 +: 8];
            end
            if (re) begin
               rd_reg <= lane_mem[addr];
            end
         end

         assign rdata[gi*8 +: 8] = rd_reg;
      end
   endgenerate

endmodule

// File: rtl/data_ram_ctrl.sv
// Memory-stage load/store responder: wait-state FSM, lane masking, ack/stall.
// Define DATA_RAM_ALIGN_CHECK_EN to suppress and flag misaligned accesses.
module data_ram_ctrl
   import data_ram_ctrl_pkg::*;
#(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           mem_ce_i,
   input  logic           mem_we_i,
   input  data_addr_bus_t mem_addr_i,
   input  byte_sel_bus_t  mem_sel_i,
   input  data_bus_t      mem_data_i,
   output data_bus_t      mem_data_o,
   output logic           mem_ack_o,
   output logic           addr_err_o,
   output logic           stall_req_o
);

   dram_state_e           state_reg;
   logic [3:0]            cnt_reg;
   logic                  we_reg;
   logic [DEPTH_LOG2-1:0] index_reg;
   byte_sel_bus_t         sel_reg;
   data_bus_t             wdata_reg;
   logic                  ack_reg;
   logic                  load_reg;
   logic                  access_now;
   logic                  misaligned;
   byte_sel_bus_t         ram_we;
   logic                  ram_re;
   data_bus_t             ram_rdata;

   // Address bits above the RAM index alias by design.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{mem_addr_i[31:DEPTH_LOG2+2], mem_addr_i[1:0]};

`ifdef DATA_RAM_ALIGN_CHECK_EN
   logic [1:0] low_addr_reg;
   logic       err_reg;
   assign misaligned = (low_addr_reg != 2'b00);
   assign addr_err_o = err_reg;

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         err_reg <= 1'b0;
      end else begin
         err_reg <= access_now && misaligned;
         if (state_reg == DRamIdle && mem_ce_i == ChipEnable) begin
            low_addr_reg <= mem_addr_i[1:0];
         end
      end
   end
`else
   assign misaligned = 1'b0;
   assign addr_err_o = 1'b0;
`endif

   assign access_now = (state_reg == DRamBusy) && (cnt_reg == 4'd0);

   // A reset landing on the access edge must not let the write through.
   assign ram_we = (access_now && we_reg == WriteEnable && !misaligned && rst != RstEnable)
                   ? sel_reg : 4'b0000;
   assign ram_re = access_now && we_reg != WriteEnable && !misaligned;

   assign mem_data_o  = load_reg ? (ram_rdata & lane_mask(sel_reg)) : ZeroWord;
   assign mem_ack_o   = ack_reg;
   assign stall_req_o = (mem_ce_i == ChipEnable) && (state_reg != DRamResp);

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_reg <= DRamIdle;
         cnt_reg   <= 4'd0;
         ack_reg   <= 1'b0;
         load_reg  <= 1'b0;
      end else begin
         ack_reg  <= 1'b0;
         load_reg <= 1'b0;
         case (state_reg)
            DRamIdle: begin
               if (mem_ce_i == ChipEnable) begin
                  we_reg    <= mem_we_i;
                  index_reg <= mem_addr_i[DEPTH_LOG2+1:2];
                  sel_reg   <= mem_sel_i;
                  wdata_reg <= mem_data_i;
                  cnt_reg   <= 4'(WAIT_STATES);
                  state_reg <= DRamBusy;
               end
            end
            DRamBusy: begin
               if (cnt_reg != 4'd0) begin
                  cnt_reg <= cnt_reg - 4'd1;
               end else begin
                  ack_reg   <= 1'b1;
                  load_reg  <= (we_reg != WriteEnable) && !misaligned;
                  state_reg <= DRamResp;
               end
            end
            DRamResp: begin
               state_reg <= DRamIdle;
            end
            default: begin
               state_reg <= DRamIdle;
            end
         endcase
      end
   end

   data_ram_array #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_array (
      .clk  (clk),
      .addr (index_reg),
      .we   (ram_we),
      .re   (ram_re),
      .wdata(wdata_reg),
      .rdata(ram_rdata)
   );

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed and randomized checks of data_ram_ctrl against a word-array model
// that tracks byte-lane stores, aliasing and (when enabled) alignment errors.
module tb_data_ram_ctrl;

   localparam int DL2 = 10;
   localparam int WS  = 1;
`ifdef DATA_RAM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_ce_i;
   logic        mem_we_i;
   logic [31:0] mem_addr_i;
   logic [3:0]  mem_sel_i;
   logic [31:0] mem_data_i;
   logic [31:0] mem_data_o;
   logic        mem_ack_o;
   logic        addr_err_o;
   logic        stall_req_o;

   int checks = 0;
   int errors = 0;

   logic [31:0] mdl [int];

   always #5 clk = ~clk;

   data_ram_ctrl #(.DEPTH_LOG2(DL2), .WAIT_STATES(WS)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_ce_i   (mem_ce_i),
      .mem_we_i   (mem_we_i),
      .mem_addr_i (mem_addr_i),
      .mem_sel_i  (mem_sel_i),
      .mem_data_i (mem_data_i),
      .mem_data_o (mem_data_o),
      .mem_ack_o  (mem_ack_o),
      .addr_err_o (addr_err_o),
      .stall_req_o(stall_req_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete request; expectations come from the word model.
   task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] data, input bit scramble, output logic [31:0] rdata);
      int          idx;
      bit          mis;
      logic [31:0] exp_d;
      logic [31:0] mask;
      int          k;
      bit          got;
      idx  = int'(addr[DL2+1:2]);
      mis  = ALIGN && (addr[1:0] != 2'b00);
      mask = '0;
      for (int b = 0; b < 4; b++) if (sel[b]) mask[b*8 +: 8] = 8'hFF;
      if (!mdl.exists(idx)) mdl[idx] = 'x;
      exp_d = (we || mis) ? 32'h0 : (mdl[idx] & mask);
      if (we && !mis) mdl[idx] = (mdl[idx] & ~mask) | (data & mask);

      @(negedge clk);
      mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = data;
      #1 check("stall_idle", 32'(stall_req_o), 32'd1);
      @(posedge clk);
      k = 0; got = 0;
      while (!got && k < 40) begin
         @(negedge clk);
         k++;
         if (mem_ack_o === 1'b1) got = 1;
         else begin
            check("stall_busy", 32'(stall_req_o), 32'd1);
            if (scramble) begin
               mem_we_i = ~mem_we_i; mem_addr_i = $urandom(); mem_sel_i = 4'($urandom());
               mem_data_i = $urandom();
            end
         end
      end
      check("ack_latency", 32'(k), 32'(WS + 2));
      rdata = mem_data_o;
      if (got) begin
         check("rdata", mem_data_o, exp_d);
         check("addr_err", 32'(addr_err_o), 32'(mis));
         check("stall_resp", 32'(stall_req_o), 32'd0);
      end
      mem_ce_i = 1'b0; mem_sel_i = 4'($urandom()); mem_data_i = $urandom();
      @(negedge clk);
      check("ack_pulse", 32'(mem_ack_o), 32'd0);
      check("stall_noce", 32'(stall_req_o), 32'd0);
      $display("%s addr=%h sel=%b data=%h rdata=%h lat=%0d",
               we ? "ST" : "LD", addr, sel, data, rdata, k);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] r;
      logic [31:0] a;
      rst = 1'b1; mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0;
      mem_sel_i = '0; mem_data_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ack", 32'(mem_ack_o), 32'd0);
      check("rst_data", mem_data_o, 32'h0);
      check("rst_stall", 32'(stall_req_o), 32'd0);
      check("rst_err", 32'(addr_err_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_ack", 32'(mem_ack_o), 32'd0);

      access(1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 0, rd);
      access(1'b0, 32'h0000_0010, 4'b1111, 32'h0, 0, rd);
      check("full_word", rd, 32'hDEAD_BEEF);

      access(1'b1, 32'h0000_0020, 4'b1111, 32'hAABB_CCDD, 0, rd);
      access(1'b1, 32'h0000_0020, 4'b0100, 32'h1122_3344, 0, rd);
      check("store_zero_data", rd, 32'h0);
      access(1'b0, 32'h0000_0020, 4'b1111, 32'h0, 0, rd);
      check("lane_merge", rd, 32'hAA22_CCDD);
      access(1'b0, 32'h0000_0020, 4'b0011, 32'h0, 0, rd);
      check("lane_mask", rd, 32'h0000_CCDD);
      access(1'b1, 32'h0000_0020, 4'b0000, 32'hFFFF_FFFF, 0, rd);
      access(1'b0, 32'h0000_0020, 4'b1111, 32'h0, 0, rd);
      check("sel_none", rd, 32'hAA22_CCDD);

      access(1'b1, 32'h0000_1004, 4'b1111, 32'h0000_0005, 0, rd);
      access(1'b0, 32'h0000_0004, 4'b1111, 32'h0, 0, rd);
      check("alias", rd, 32'h0000_0005);

      // Reset while the second store is waiting in BUSY.
      access(1'b1, 32'h0000_0030, 4'b1111, 32'h0, 0, rd);
      @(negedge clk);
      mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h30; mem_sel_i = 4'hF;
      mem_data_i = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; mem_ce_i = 1'b0;
      for (int i = 0; i < WS + 3; i++) begin
         check("rst_busy_noack", 32'(mem_ack_o), 32'd0);
         @(negedge clk);
      end
      access(1'b0, 32'h0000_0030, 4'b1111, 32'h0, 0, rd);
      check("rst_busy_nowrite", rd, 32'h0);

      access(1'b1, 32'h0000_0031, 4'b1111, 32'h1234_5678, 0, rd);
      access(1'b0, 32'h0000_0030, 4'b1111, 32'h0, 0, rd);
      check("misaligned_store", rd, ALIGN ? 32'h0 : 32'h1234_5678);

      // Randomized phase over a 16-word window with random alias bits.
      for (int w = 0; w < 16; w++) begin
         r = $urandom();
         a = {r[31:12], 6'h08, 4'(w), 2'b00};
         access(1'b1, a, 4'b1111, $urandom(), 1, rd);
      end
      for (int n = 0; n < 60; n++) begin
         r = $urandom();
         a = {r[31:12], 6'h08, r[5:2], (r[8:7] == 2'b00) ? r[1:0] : 2'b00};
         access(r[9], a, r[13:10], $urandom(), r[14], rd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
